// File: rtl/decode_ctrl_mc_if.sv
// Decode/control bus between the ID stage and the decode_ctrl_mc unit.
//   master : ID stage side, drives opcode, qualifiers and operands, receives controls.
//   slave  : decoder side, receives opcode/operands, drives controls, flags and stall.
interface decode_ctrl_mc_if #(
    parameter int unsigned WORD_LEN    = 32,
    parameter int unsigned OP_CODE_LEN = 6,
    parameter int unsigned EXE_CMD_LEN = 4
);
    logic [OP_CODE_LEN-1:0] opCode;
    logic                   valid;
    logic                   hazard_detected;
    logic                   flush;
    logic [WORD_LEN-1:0]    src1;
    logic [WORD_LEN-1:0]    src2;

    logic [EXE_CMD_LEN-1:0] EXE_CMD;
    logic [1:0]             Branch_command;
    logic                   Is_Imm;
    logic                   ST_or_BNE;
    logic                   WB_EN;
    logic                   MEM_R_EN;
    logic                   MEM_W_EN;
    logic                   branchEn;
    logic                   jumpEnable;
    logic                   Z;
    logic                   N;
    logic                   stall;

    modport master (
        output opCode, valid, hazard_detected, flush, src1, src2,
        input  EXE_CMD, Branch_command, Is_Imm, ST_or_BNE, WB_EN, MEM_R_EN, MEM_W_EN,
        input  branchEn, jumpEnable, Z, N, stall
    );

    modport slave (
        input  opCode, valid, hazard_detected, flush, src1, src2,
        output EXE_CMD, Branch_command, Is_Imm, ST_or_BNE, WB_EN, MEM_R_EN, MEM_W_EN,
        output branchEn, jumpEnable, Z, N, stall
    );
endinterface

// File: rtl/decode_ctrl_mc.sv
// ID-stage decode/control unit with Z/N flag register and multi-cycle MULT sequencing.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (state IDLE, counter 0, flags 0, outputs 0)
//   bus   : decode_ctrl_mc_if.slave
//           in  opCode, valid, hazard_detected, flush, src1, src2
//           out EXE_CMD, Branch_command, Is_Imm, ST_or_BNE, WB_EN, MEM_R_EN, MEM_W_EN,
//               branchEn, jumpEnable, Z, N (registered), stall
// Decode outputs are combinational from opCode and state; only state, counter and flags
// are registered.
module decode_ctrl_mc #(
    parameter int unsigned WORD_LEN    = 32,
    parameter int unsigned OP_CODE_LEN = 6,
    parameter int unsigned EXE_CMD_LEN = 4,
    parameter int unsigned MULT_CYCLES = 4
) (
    input logic             clk,
    input logic             rst_n,
    decode_ctrl_mc_if.slave bus
);

    // Encodings track defines.v (OP_*, EXE_*, COND_*).
    localparam logic [OP_CODE_LEN-1:0] OpAdd  = OP_CODE_LEN'(1);
    localparam logic [OP_CODE_LEN-1:0] OpSub  = OP_CODE_LEN'(3);
    localparam logic [OP_CODE_LEN-1:0] OpAnd  = OP_CODE_LEN'(5);
    localparam logic [OP_CODE_LEN-1:0] OpSll  = OP_CODE_LEN'(10);
    localparam logic [OP_CODE_LEN-1:0] OpCmp  = OP_CODE_LEN'(13);
    localparam logic [OP_CODE_LEN-1:0] OpMult = OP_CODE_LEN'(14);
    localparam logic [OP_CODE_LEN-1:0] OpAddi = OP_CODE_LEN'(32);
    localparam logic [OP_CODE_LEN-1:0] OpLw   = OP_CODE_LEN'(36);
    localparam logic [OP_CODE_LEN-1:0] OpSw   = OP_CODE_LEN'(37);
    localparam logic [OP_CODE_LEN-1:0] OpBne  = OP_CODE_LEN'(41);
    localparam logic [OP_CODE_LEN-1:0] OpJmp  = OP_CODE_LEN'(42);

    localparam logic [EXE_CMD_LEN-1:0] ExeAdd  = EXE_CMD_LEN'(0);
    localparam logic [EXE_CMD_LEN-1:0] ExeSub  = EXE_CMD_LEN'(2);
    localparam logic [EXE_CMD_LEN-1:0] ExeAnd  = EXE_CMD_LEN'(4);
    localparam logic [EXE_CMD_LEN-1:0] ExeSll  = EXE_CMD_LEN'(8);
    localparam logic [EXE_CMD_LEN-1:0] ExeMult = EXE_CMD_LEN'(11);
    localparam logic [EXE_CMD_LEN-1:0] ExeNop  = EXE_CMD_LEN'(15);

    localparam logic [1:0] CondJump = 2'd1;
    localparam logic [1:0] CondBne  = 2'd3;

    // Keep at least one counter bit so MULT_CYCLES=1 still elaborates.
    localparam int unsigned CntW = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;

    typedef enum logic {StIdle, StBusy} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            z_q, z_d;
    logic            n_q, n_d;

    logic [EXE_CMD_LEN-1:0] exe_cmd;
    logic [1:0]             br_cmd;
    logic                   is_imm, st_or_bne, wb_en, mem_r_en, mem_w_en;
    logic                   br_en, jmp_en, stall;
    logic                   issue;

    // A real instruction only issues from IDLE with no bubble request.
    assign issue = (state_q == StIdle) && bus.valid && !bus.hazard_detected && !bus.flush;

    always_comb begin
        exe_cmd   = '0;
        br_cmd    = 2'd0;
        is_imm    = 1'b0;
        st_or_bne = 1'b0;
        wb_en     = 1'b0;
        mem_r_en  = 1'b0;
        mem_w_en  = 1'b0;
        br_en     = 1'b0;
        jmp_en    = 1'b0;
        stall     = 1'b0;
        state_d   = state_q;
        cnt_d     = cnt_q;
        z_d       = z_q;
        n_d       = n_q;

        // Outputs are forced low for as long as reset is held, whatever the inputs.
        if (rst_n) begin
            unique case (state_q)
                StIdle: begin
                    if (issue) begin
                        unique case (bus.opCode)
                            OpAdd: begin exe_cmd = ExeAdd; wb_en = 1'b1; end
                            OpSub: begin exe_cmd = ExeSub; wb_en = 1'b1; end
                            OpAnd: begin exe_cmd = ExeAnd; wb_en = 1'b1; end
                            OpSll: begin exe_cmd = ExeSll; wb_en = 1'b1; end
                            OpAddi: begin
                                exe_cmd = ExeAdd;
                                wb_en   = 1'b1;
                                is_imm  = 1'b1;
                            end
                            OpLw: begin
                                exe_cmd   = ExeAdd;
                                wb_en     = 1'b1;
                                is_imm    = 1'b1;
                                st_or_bne = 1'b1;
                                mem_r_en  = 1'b1;
                            end
                            OpSw: begin
                                exe_cmd   = ExeAdd;
                                is_imm    = 1'b1;
                                st_or_bne = 1'b1;
                                mem_w_en  = 1'b1;
                            end
                            OpCmp: begin
                                exe_cmd = ExeNop;
                                z_d     = (bus.src1 == bus.src2);
                                // True signed compare: immune to subtraction overflow.
                                n_d     = ($signed(bus.src1) < $signed(bus.src2));
                            end
                            OpBne: begin
                                exe_cmd = ExeNop;
                                is_imm  = 1'b1;
                                br_cmd  = CondBne;
                                br_en   = ~z_q;
                            end
                            OpJmp: begin
                                exe_cmd = ExeNop;
                                is_imm  = 1'b1;
                                br_cmd  = CondJump;
                                br_en   = 1'b1;
                                jmp_en  = 1'b1;
                            end
                            OpMult: begin
                                exe_cmd = ExeMult;
                                if (MULT_CYCLES == 1) begin
                                    wb_en = 1'b1;
                                end else begin
                                    stall   = 1'b1;
                                    state_d = StBusy;
                                    // Issue cycle counts as the first; BUSY counts down
                                    // the remaining MULT_CYCLES-1 cycles to 0.
                                    cnt_d   = CntW'(MULT_CYCLES - 2);
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                StBusy: begin
                    if (bus.flush) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        exe_cmd = ExeMult;
                        wb_en   = (cnt_q == '0);
                        stall   = (cnt_q != '0);
                        if (cnt_q == '0) begin
                            state_d = StIdle;
                        end else begin
                            cnt_d = cnt_q - CntW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            n_q     <= n_d;
        end
    end

    assign bus.EXE_CMD        = exe_cmd;
    assign bus.Branch_command = br_cmd;
    assign bus.Is_Imm         = is_imm;
    assign bus.ST_or_BNE      = st_or_bne;
    assign bus.WB_EN          = wb_en;
    assign bus.MEM_R_EN       = mem_r_en;
    assign bus.MEM_W_EN       = mem_w_en;
    assign bus.branchEn       = br_en;
    assign bus.jumpEnable     = jmp_en;
    assign bus.Z              = z_q;
    assign bus.N              = n_q;
    assign bus.stall          = stall;

endmodule

// File: tb/tb_decode_ctrl_mc.sv
// Bench for decode_ctrl_mc: two instances (MULT_CYCLES=4 and 1) share one stimulus stream.
// Expected output vectors are pushed to a scoreboard when stimulus is driven and popped
// at the following negedge, where the combinational outputs are sampled.
module tb_decode_ctrl_mc;

    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd3;
    localparam logic [5:0] OP_AND  = 6'd5;
    localparam logic [5:0] OP_SLL  = 6'd10;
    localparam logic [5:0] OP_CMP  = 6'd13;
    localparam logic [5:0] OP_MULT = 6'd14;
    localparam logic [5:0] OP_ADDI = 6'd32;
    localparam logic [5:0] OP_LW   = 6'd36;
    localparam logic [5:0] OP_SW   = 6'd37;
    localparam logic [5:0] OP_BNE  = 6'd41;
    localparam logic [5:0] OP_JMP  = 6'd42;
    localparam logic [5:0] OP_BAD  = 6'd63;

    localparam logic [3:0] EXE_ADD  = 4'd0;
    localparam logic [3:0] EXE_SUB  = 4'd2;
    localparam logic [3:0] EXE_AND  = 4'd4;
    localparam logic [3:0] EXE_SLL  = 4'd8;
    localparam logic [3:0] EXE_MULT = 4'd11;
    localparam logic [3:0] EXE_NOP  = 4'd15;

    // Vector: EXE_CMD[15:12] Branch_command[11:10]
    //         Is_Imm ST_or_BNE WB_EN MEM_R_EN MEM_W_EN branchEn jumpEnable Z N stall
    localparam logic [15:0] C_ZERO   = 16'h0;
    localparam logic [15:0] C_ADD    = {EXE_ADD,  2'd0, 10'b0010000000};
    localparam logic [15:0] C_SUB    = {EXE_SUB,  2'd0, 10'b0010000000};
    localparam logic [15:0] C_AND    = {EXE_AND,  2'd0, 10'b0010000000};
    localparam logic [15:0] C_SLL    = {EXE_SLL,  2'd0, 10'b0010000000};
    localparam logic [15:0] C_ADDI   = {EXE_ADD,  2'd0, 10'b1010000000};
    localparam logic [15:0] C_LW     = {EXE_ADD,  2'd0, 10'b1111000000};
    localparam logic [15:0] C_SW     = {EXE_ADD,  2'd0, 10'b1100100000};
    localparam logic [15:0] C_CMP    = {EXE_NOP,  2'd0, 10'b0000000000};
    localparam logic [15:0] C_BNE_NT = {EXE_NOP,  2'd3, 10'b1000000000};
    localparam logic [15:0] C_BNE_T  = {EXE_NOP,  2'd3, 10'b1000010000};
    localparam logic [15:0] C_JMP    = {EXE_NOP,  2'd1, 10'b1000011000};
    localparam logic [15:0] C_MUL_ST = {EXE_MULT, 2'd0, 10'b0000000001};
    localparam logic [15:0] C_MUL_WB = {EXE_MULT, 2'd0, 10'b0010000000};

    typedef struct {
        logic [5:0]  op;
        logic        v;
        logic        h;
        logic        f;
        logic [31:0] a;
        logic [31:0] b;
        logic [15:0] e4;
        logic [15:0] e1;
        string       name;
    } stim_t;

    typedef struct {
        logic [15:0] e4;
        logic [15:0] e1;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  op;
    logic        vld, haz, fl;
    logic [31:0] s1, s2;
    logic [15:0] out4, out1;

    stim_t stq[$];
    exp_t  sb[$];
    int    n_cmp  = 0;
    int    n_fail = 0;

    always #5 clk = ~clk;

    decode_ctrl_mc_if #(.WORD_LEN(32), .OP_CODE_LEN(6), .EXE_CMD_LEN(4)) bus4 ();
    decode_ctrl_mc_if #(.WORD_LEN(32), .OP_CODE_LEN(6), .EXE_CMD_LEN(4)) bus1 ();

    assign bus4.opCode = op;  assign bus4.valid = vld;  assign bus4.hazard_detected = haz;
    assign bus4.flush  = fl;  assign bus4.src1  = s1;   assign bus4.src2            = s2;
    assign bus1.opCode = op;  assign bus1.valid = vld;  assign bus1.hazard_detected = haz;
    assign bus1.flush  = fl;  assign bus1.src1  = s1;   assign bus1.src2            = s2;

    assign out4 = {bus4.EXE_CMD, bus4.Branch_command, bus4.Is_Imm, bus4.ST_or_BNE, bus4.WB_EN,
                   bus4.MEM_R_EN, bus4.MEM_W_EN, bus4.branchEn, bus4.jumpEnable, bus4.Z,
                   bus4.N, bus4.stall};
    assign out1 = {bus1.EXE_CMD, bus1.Branch_command, bus1.Is_Imm, bus1.ST_or_BNE, bus1.WB_EN,
                   bus1.MEM_R_EN, bus1.MEM_W_EN, bus1.branchEn, bus1.jumpEnable, bus1.Z,
                   bus1.N, bus1.stall};

    decode_ctrl_mc #(.WORD_LEN(32), .OP_CODE_LEN(6), .EXE_CMD_LEN(4), .MULT_CYCLES(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    decode_ctrl_mc #(.WORD_LEN(32), .OP_CODE_LEN(6), .EXE_CMD_LEN(4), .MULT_CYCLES(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    function automatic logic [15:0] flg(input logic z, input logic n);
        return {13'd0, z, n, 1'b0};
    endfunction

    task automatic drive(input logic [5:0] o, input logic v, input logic h, input logic f,
                         input logic [31:0] a, input logic [31:0] b);
        op = o; vld = v; haz = h; fl = f; s1 = a; s2 = b;
    endtask

    task automatic st(input logic [5:0] o, input logic v, input logic h, input logic f,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [15:0] e4, input logic [15:0] e1, input string name);
        stim_t s;
        s.op = o; s.v = v; s.h = h; s.f = f; s.a = a; s.b = b;
        s.e4 = e4; s.e1 = e1; s.name = name;
        stq.push_back(s);
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        drive(OP_ADD, 1'b1, 1'b0, 1'b0, 32'd1, 32'd2);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) drive(OP_MULT, 1'b1, 1'b0, 1'b0, 32'd7, 32'd7);
            if (i == 2) drive(OP_JMP, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd0);
            sb.push_back('{C_ZERO, C_ZERO, "reset_hold"});
            #3;
            e = sb.pop_front();
            n_cmp++;
            if (out4 !== e.e4) begin
                n_fail++;
                $display("FAIL %s (mc4): got %h, expected %h", e.name, out4, e.e4);
            end
            n_cmp++;
            if (out1 !== e.e1) begin
                n_fail++;
                $display("FAIL %s (mc1): got %h, expected %h", e.name, out1, e.e1);
            end
            @(posedge clk);
        end
        #1 rst_n = 1'b1;
        st(OP_ADD, 1, 0, 0, 32'd0, 32'd0, C_ADD, C_ADD, "add_after_reset");
        while (stq.size() > 0) begin
            stim_t s = stq.pop_front();
            drive(s.op, s.v, s.h, s.f, s.a, s.b);
            sb.push_back('{s.e4, s.e1, s.name});
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if (out4 !== e.e4) begin
                n_fail++;
                $display("FAIL %s (mc4): got %h, expected %h", e.name, out4, e.e4);
            end
            n_cmp++;
            if (out1 !== e.e1) begin
                n_fail++;
                $display("FAIL %s (mc1): got %h, expected %h", e.name, out1, e.e1);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_decode();
        exp_t e;
        st(OP_SUB,  1, 0, 0, 0, 0, C_SUB,   C_SUB,   "sub");
        st(OP_AND,  1, 0, 0, 0, 0, C_AND,   C_AND,   "and");
        st(OP_SLL,  1, 0, 0, 0, 0, C_SLL,   C_SLL,   "sll");
        st(OP_ADDI, 1, 0, 0, 0, 0, C_ADDI,  C_ADDI,  "addi");
        st(OP_LW,   1, 0, 0, 0, 0, C_LW,    C_LW,    "lw");
        st(OP_SW,   1, 0, 0, 0, 0, C_SW,    C_SW,    "sw");
        st(OP_JMP,  1, 0, 0, 0, 0, C_JMP,   C_JMP,   "jmp");
        st(OP_BAD,  1, 0, 0, 0, 0, C_ZERO,  C_ZERO,  "unknown_op");
        st(OP_BNE,  1, 0, 0, 0, 0, C_BNE_T, C_BNE_T, "bne_z0_after_reset");
        st(OP_CMP,  1, 0, 0, 32'd9, 32'd2, C_CMP, C_CMP, "cmp_9_2");
        while (stq.size() > 0) begin
            stim_t s = stq.pop_front();
            drive(s.op, s.v, s.h, s.f, s.a, s.b);
            sb.push_back('{s.e4, s.e1, s.name});
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if (out4 !== e.e4) begin
                n_fail++;
                $display("FAIL %s (mc4): got %h, expected %h", e.name, out4, e.e4);
            end
            n_cmp++;
            if (out1 !== e.e1) begin
                n_fail++;
                $display("FAIL %s (mc1): got %h, expected %h", e.name, out1, e.e1);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flags();
        exp_t e;
        st(OP_CMP, 1, 0, 0, 32'd5, 32'd5, C_CMP | flg(0, 0), C_CMP | flg(0, 0), "cmp_5_5");
        st(OP_ADD, 1, 0, 0, 0, 0, C_ADD | flg(1, 0), C_ADD | flg(1, 0), "flags_eq");
        st(OP_CMP, 1, 0, 0, 32'hFFFF_FFFF, 32'd1, C_CMP | flg(1, 0), C_CMP | flg(1, 0),
           "cmp_m1_1");
        st(OP_ADD, 1, 0, 0, 0, 0, C_ADD | flg(0, 1), C_ADD | flg(0, 1), "flags_m1_lt_1");
        st(OP_CMP, 1, 0, 0, 32'h7FFF_FFFF, 32'h8000_0000, C_CMP | flg(0, 1),
           C_CMP | flg(0, 1), "cmp_max_min");
        st(OP_ADD, 1, 0, 0, 0, 0, C_ADD | flg(0, 0), C_ADD | flg(0, 0), "flags_max_gt_min");
        st(OP_CMP, 1, 0, 0, 32'h8000_0000, 32'd1, C_CMP | flg(0, 0), C_CMP | flg(0, 0),
           "cmp_min_1");
        st(OP_ADD, 1, 0, 0, 0, 0, C_ADD | flg(0, 1), C_ADD | flg(0, 1), "flags_min_lt_1");
        while (stq.size() > 0) begin
            stim_t s = stq.pop_front();
            drive(s.op, s.v, s.h, s.f, s.a, s.b);
            sb.push_back('{s.e4, s.e1, s.name});
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if (out4 !== e.e4) begin
                n_fail++;
                $display("FAIL %s (mc4): got %h, expected %h", e.name, out4, e.e4);
            end
            n_cmp++;
            if (out1 !== e.e1) begin
                n_fail++;
                $display("FAIL %s (mc1): got %h, expected %h", e.name, out1, e.e1);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_bne();
        exp_t e;
        st(OP_CMP, 1, 0, 0, 32'd3, 32'd3, C_CMP | flg(0, 1), C_CMP | flg(0, 1), "cmp_3_3");
        st(OP_BNE, 1, 0, 0, 0, 0, C_BNE_NT | flg(1, 0), C_BNE_NT | flg(1, 0), "bne_not_taken");
        st(OP_CMP, 1, 0, 0, 32'd3, 32'd4, C_CMP | flg(1, 0), C_CMP | flg(1, 0), "cmp_3_4");
        st(OP_BNE, 1, 0, 0, 0, 0, C_BNE_T | flg(0, 1), C_BNE_T | flg(0, 1), "bne_taken");
        while (stq.size() > 0) begin
            stim_t s = stq.pop_front();
            drive(s.op, s.v, s.h, s.f, s.a, s.b);
            sb.push_back('{s.e4, s.e1, s.name});
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if (out4 !== e.e4) begin
                n_fail++;
                $display("FAIL %s (mc4): got %h, expected %h", e.name, out4, e.e4);
            end
            n_cmp++;
            if (out1 !== e.e1) begin
                n_fail++;
                $display("FAIL %s (mc1): got %h, expected %h", e.name, out1, e.e1);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_hazard();
        exp_t e;
        st(OP_SW,  1, 1, 0, 0, 0, flg(0, 1), flg(0, 1), "sw_hazard");
        st(OP_SW,  1, 0, 0, 0, 0, C_SW | flg(0, 1), C_SW | flg(0, 1), "sw_clean");
        st(OP_ADD, 0, 0, 0, 0, 0, flg(0, 1), flg(0, 1), "add_invalid");
        st(OP_LW,  1, 1, 1, 0, 0, flg(0, 1), flg(0, 1), "lw_flush_hazard");
        st(OP_JMP, 1, 0, 1, 0, 0, flg(0, 1), flg(0, 1), "jmp_flush");
        st(OP_CMP, 1, 1, 0, 32'd5, 32'd5, flg(0, 1), flg(0, 1), "cmp_hazard");
        st(OP_CMP, 1, 0, 1, 32'd5, 32'd5, flg(0, 1), flg(0, 1), "cmp_flush");
        st(OP_ADD, 1, 0, 0, 0, 0, C_ADD | flg(0, 1), C_ADD | flg(0, 1), "flags_held");
        st(OP_CMP, 1, 0, 0, 32'd9, 32'd2, C_CMP | flg(0, 1), C_CMP | flg(0, 1), "cmp_9_2b");
        st(OP_ADD, 1, 0, 0, 0, 0, C_ADD, C_ADD, "flags_cleared");
        while (stq.size() > 0) begin
            stim_t s = stq.pop_front();
            drive(s.op, s.v, s.h, s.f, s.a, s.b);
            sb.push_back('{s.e4, s.e1, s.name});
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if (out4 !== e.e4) begin
                n_fail++;
                $display("FAIL %s (mc4): got %h, expected %h", e.name, out4, e.e4);
            end
            n_cmp++;
            if (out1 !== e.e1) begin
                n_fail++;
                $display("FAIL %s (mc1): got %h, expected %h", e.name, out1, e.e1);
            end
            @(posedge clk); #1;
        end
    endtask

    // Cycles 2..4 carry unrelated stimulus: the 4-cycle unit must ignore it while busy,
    // the 1-cycle unit is already idle and decodes it.
    task automatic test_mult();
        exp_t e;
        st(OP_MULT, 1, 0, 0, 0, 0, C_MUL_ST, C_MUL_WB, "mult_c1");
        st(OP_ADD,  1, 0, 0, 0, 0, C_MUL_ST, C_ADD,    "mult_c2");
        st(OP_SW,   1, 1, 0, 0, 0, C_MUL_ST, C_ZERO,   "mult_c3");
        st(OP_ADD,  0, 0, 0, 0, 0, C_MUL_WB, C_ZERO,   "mult_c4");
        st(OP_ADD,  1, 0, 0, 0, 0, C_ADD,    C_ADD,    "after_mult_c5");
        st(OP_MULT, 1, 0, 0, 0, 0, C_MUL_ST, C_MUL_WB, "mult_fl_c1");
        st(OP_MULT, 1, 0, 1, 0, 0, C_ZERO,   C_ZERO,   "mult_flush_c2");
        st(OP_ADD,  1, 0, 0, 0, 0, C_ADD,    C_ADD,    "after_flush");
        while (stq.size() > 0) begin
            stim_t s = stq.pop_front();
            drive(s.op, s.v, s.h, s.f, s.a, s.b);
            sb.push_back('{s.e4, s.e1, s.name});
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if (out4 !== e.e4) begin
                n_fail++;
                $display("FAIL %s (mc4): got %h, expected %h", e.name, out4, e.e4);
            end
            n_cmp++;
            if (out1 !== e.e1) begin
                n_fail++;
                $display("FAIL %s (mc1): got %h, expected %h", e.name, out1, e.e1);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mult_reset();
        exp_t e;
        st(OP_CMP,  1, 0, 0, 32'd3, 32'd4, C_CMP, C_CMP, "cmp_before_rst");
        st(OP_MULT, 1, 0, 0, 0, 0, C_MUL_ST | flg(0, 1), C_MUL_WB | flg(0, 1), "mult_rst_c1");
        for (int k = 0; k < 3; k++) begin
            if (k < 2) begin
                stim_t s = stq.pop_front();
                drive(s.op, s.v, s.h, s.f, s.a, s.b);
                sb.push_back('{s.e4, s.e1, s.name});
                @(negedge clk);
            end else begin
                // Second BUSY cycle: check just after the edge, then reset mid-cycle.
                drive(OP_ADD, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
                sb.push_back('{C_MUL_ST | flg(0, 1), C_ADD | flg(0, 1), "mult_rst_c2"});
                sb.push_back('{C_ZERO, C_ZERO, "async_rst_busy"});
                #2;
            end
            e = sb.pop_front();
            n_cmp++;
            if (out4 !== e.e4) begin
                n_fail++;
                $display("FAIL %s (mc4): got %h, expected %h", e.name, out4, e.e4);
            end
            n_cmp++;
            if (out1 !== e.e1) begin
                n_fail++;
                $display("FAIL %s (mc1): got %h, expected %h", e.name, out1, e.e1);
            end
            if (k < 2) begin
                @(posedge clk); #1;
            end
        end
        rst_n = 1'b0;
        #1;
        e = sb.pop_front();
        n_cmp++;
        if (out4 !== e.e4) begin
            n_fail++;
            $display("FAIL %s (mc4): got %h, expected %h", e.name, out4, e.e4);
        end
        n_cmp++;
        if (out1 !== e.e1) begin
            n_fail++;
            $display("FAIL %s (mc1): got %h, expected %h", e.name, out1, e.e1);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        st(OP_ADD, 1, 0, 0, 0, 0, C_ADD, C_ADD, "add_after_async_rst");
        while (stq.size() > 0) begin
            stim_t s = stq.pop_front();
            drive(s.op, s.v, s.h, s.f, s.a, s.b);
            sb.push_back('{s.e4, s.e1, s.name});
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if (out4 !== e.e4) begin
                n_fail++;
                $display("FAIL %s (mc4): got %h, expected %h", e.name, out4, e.e4);
            end
            n_cmp++;
            if (out1 !== e.e1) begin
                n_fail++;
                $display("FAIL %s (mc1): got %h, expected %h", e.name, out1, e.e1);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_flags();
        test_bne();
        test_hazard();
        test_mult();
        test_mult_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_ctrl_mc.md
# decode_ctrl_mc

Parametrised decode/control unit for the 5-stage pipeline's ID stage. It decodes `opCode` into execute, memory and write-back control, and holds a registered Z/N condition-flag pair updated by CMP. It resolves BNE against those flags and sequences a multi-cycle MULT with a stall handshake to IF/ID. It replaces the purely combinational decoder: it adds flush, explicit bubble semantics on hazard, a flag register, and a MULT state machine.

## Interface
Parameters:
- `WORD_LEN`, 32, operand width for CMP.
- `OP_CODE_LEN`, 6, opcode width; encodings are the `OP_*` macros in `defines.v`.
- `EXE_CMD_LEN`, 4, ALU command width; values are the `EXE_*` macros.
- `MULT_CYCLES`, 4, total cycles a MULT occupies the ID stage; legal range 1..16.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `opCode` in OP_CODE_LEN: opcode of the instruction in ID.
- `valid` in 1: ID holds a real instruction.
- `hazard_detected` in 1: insert bubble this cycle.
- `flush` in 1: squash ID (taken branch or jump downstream).
- `src1`, `src2` in WORD_LEN: register operands.
- `EXE_CMD` out EXE_CMD_LEN: ALU command.
- `Branch_command` out 2: `COND_BNE` / `COND_JUMP` / 0.
- `Is_Imm`, `ST_or_BNE`, `WB_EN`, `MEM_R_EN`, `MEM_W_EN` out 1 each: stage controls.
- `branchEn` out 1: branch taken this cycle.
- `jumpEnable` out 1: unconditional jump this cycle.
- `Z`, `N` out 1 each: registered flags.
- `stall` out 1: freeze PC and the IF/ID register.

## Operation
- Reset value of every output is 0. Asynchronously on `rst_n` low: state=IDLE, counter=0, Z=N=0.
- Decode outputs are combinational from `opCode` and state. Any field not listed for an opcode is 0.
- Decode table in IDLE with valid=1, hazard_detected=0, flush=0:
  - ADD/SUB/AND/SLL: EXE_CMD = `EXE_ADD`/`EXE_SUB`/`EXE_AND`/`EXE_SLL`; WB_EN=1.
  - ADDI: EXE_ADD; WB_EN=1; Is_Imm=1.
  - LW: EXE_ADD; WB_EN, Is_Imm, ST_or_BNE, MEM_R_EN = 1.
  - SW: EXE_ADD; Is_Imm, ST_or_BNE, MEM_W_EN = 1.
  - CMP: EXE_NO_OPERATION; all controls 0. Flags update at the next edge.
  - BNE: EXE_NO_OPERATION; Is_Imm=1; Branch_command=COND_BNE; branchEn = ~Z, using the registered Z.
  - JMP: EXE_NO_OPERATION; Is_Imm=1; Branch_command=COND_JUMP; branchEn=1; jumpEnable=1.
  - MULT: EXE_CMD=EXE_MULT. See the FSM below.
  - Unknown opcode: all 0.
- Bubble: if valid=0, hazard_detected=1 or flush=1 while in IDLE, every control output is 0. There is no flag update and no MULT issue.
- Flags: on an edge where a CMP is decoded as issued (the IDLE conditions above):
  - Z ← (src1 == src2).
  - N ← signed(src1) < signed(src2). This is a true signed compare, not the sign of the difference, so overflow has no effect.
  - Otherwise Z and N hold.
- MULT FSM, states IDLE and BUSY, with counter `cnt` of width ceil(log2(MULT_CYCLES)):
  - IDLE, MULT issued, MULT_CYCLES=1: WB_EN=1, stall=0; stay in IDLE.
  - IDLE, MULT issued, MULT_CYCLES>1: WB_EN=0, stall=1; next state BUSY with cnt=MULT_CYCLES-2.
  - BUSY: EXE_CMD=EXE_MULT; WB_EN=(cnt==0); stall=(cnt!=0); cnt decrements. When cnt==0, next state is IDLE.
  - BUSY ignores `opCode`, `valid` and `hazard_detected`. The instruction is held upstream by `stall`.
  - flush in BUSY: all outputs 0 this cycle, next state IDLE, cnt=0.

## Timing
- Decode latency is 0 cycles (combinational). Flags become visible 1 cycle after the CMP cycle.
- A BNE in the cycle directly after a CMP sees the new flags. A BNE in the same cycle as CMP is impossible, since only one instruction occupies ID.
- MULT holds ID for exactly MULT_CYCLES cycles:
  - stall is high for the first MULT_CYCLES-1 of them.
  - WB_EN pulses high for exactly 1 cycle, the last one.
  - The next instruction decodes in the cycle after that.
- Simultaneous events:
  - flush overrides hazard_detected.
  - In BUSY, flush is the only input that matters.
  - CMP together with hazard_detected performs no flag update.
- Reset mid-MULT: immediate return to IDLE with stall=0.

## Test plan
- Reset: hold rst_n=0 with arbitrary inputs → all outputs 0. Release, then ADD, valid → EXE_CMD=EXE_ADD, WB_EN=1.
- Flags: CMP with src1=5, src2=5 → next cycle Z=1, N=0. CMP with src1=32'hFFFFFFFF, src2=1 → Z=0, N=1. CMP with src1=32'h7FFFFFFF, src2=32'h80000000 → N=0.
- BNE: CMP 3,3 then BNE → branchEn=0. CMP 3,4 then BNE → branchEn=1 and Branch_command=COND_BNE.
- MULT with MULT_CYCLES=4 → stall=1,1,1,0 and WB_EN=0,0,0,1 over 4 cycles. Next ADD decodes in cycle 5. Rerun with MULT_CYCLES=1 → stall never asserts, WB_EN=1 at once.
- Hazard/flush: SW with hazard_detected=1 → MEM_W_EN=0, WB_EN=0. CMP with hazard → flags unchanged. flush in the 2nd BUSY cycle → outputs 0, IDLE next.
- Async reset in the 2nd BUSY cycle → stall drops without waiting for a clock edge. Z, N and the state return to 0/IDLE.
